// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrated multiplexer with a single registered output stage.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1) selection, valid/ready on
// every input and on the output, one beat per cycle under continuous demand.
module rr_arb_mux #(
  parameter int unsigned LENGTH    = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned MODE      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*LENGTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [LENGTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [LENGTH-1:0]    r_data;
  logic [SEL_WIDTH-1:0] r_sel;
  logic                 r_valid;
  logic [SEL_WIDTH-1:0] r_ptr;

  logic [SEL_WIDTH-1:0] w_base;
  logic [CHANNELS-1:0]  w_rot;
  logic [SEL_WIDTH-1:0] w_off;
  logic [SEL_WIDTH:0]   w_sum;
  logic [SEL_WIDTH-1:0] w_gidx;
  logic                 w_any;
  logic [CHANNELS-1:0]  w_grant;
  logic                 w_can_load;
  logic                 w_accept;
  logic [LENGTH-1:0]    w_mux;
  logic [SEL_WIDTH-1:0] w_ptr_next;

  // Fixed priority always scans from index 0.
  assign w_base     = (MODE == 1) ? '0 : r_ptr;
  assign w_can_load = !r_valid || out_ready;

  // Rotate requests so the scan starts at w_base, then take the first set bit.
  always_comb begin
    w_rot = CHANNELS'({in_valid, in_valid} >> w_base);
    w_off = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_off = SEL_WIDTH'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute channel index, modulo CHANNELS.
  always_comb begin
    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= (SEL_WIDTH + 1)'(CHANNELS)) begin
      w_sum = w_sum - (SEL_WIDTH + 1)'(CHANNELS);
    end
    w_gidx  = w_sum[SEL_WIDTH-1:0];
    w_grant = w_any ? (CHANNELS'(1) << w_gidx) : '0;
  end

  // One-hot data select from the granted channel.
  always_comb begin
    w_mux = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (w_grant[j]) begin
        w_mux = w_mux | in_data[j*LENGTH +: LENGTH];
      end
    end
  end

  assign in_ready   = rst ? '0 : (w_grant & {CHANNELS{w_can_load}});
  assign w_accept   = w_any && w_can_load && !rst;
  assign w_ptr_next = (w_gidx == SEL_WIDTH'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;

  // Output register and round-robin pointer: load on accept, clear valid on a bare drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_data  <= w_mux;
      r_sel   <= w_gidx;
      r_valid <= 1'b1;
      if (MODE == 0) begin
        r_ptr <= w_ptr_next;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a round-robin and a fixed-priority instance share the same inputs
// and are compared against a queue-free behavioural model of the arbitration rules.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [3:0]  vld;
  logic        ordy;
  logic [3:0]  rdy [2];
  logic [7:0]  od  [2];
  logic [1:0]  os  [2];
  logic        ov  [2];

  int total;
  int bad;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  logic [1:0] m_sel   [2];
  int         m_ptr   [2];

  rr_arb_mux #(.LENGTH(8), .CHANNELS(4), .SEL_WIDTH(2), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy[0]),
    .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(ordy)
  );

  rr_arb_mux #(.LENGTH(8), .CHANNELS(4), .SEL_WIDTH(2), .MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy[1]),
    .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner index for a request set, or -1 if nobody requests.
  function automatic int exp_grant(input int m, input logic [3:0] v, input int ptr);
    int start;
    start = (m == 0) ? ptr : 0;
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int m);
    int g;
    g = exp_grant(m, vld, m_ptr[m]);
    if (rst || g < 0 || !(!m_valid[m] || ordy)) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_data[m]  = 8'h00;
      m_sel[m]   = 2'd0;
      m_ptr[m]   = 0;
    end
  endfunction

  function automatic void model_edge();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = exp_grant(m, vld, m_ptr[m]);
      if (!m_valid[m] || ordy) begin
        if (g >= 0) begin
          m_valid[m] = 1'b1;
          m_data[m]  = din[g*8 +: 8];
          m_sel[m]   = 2'(g);
          if (m == 0) m_ptr[m] = (g + 1) % 4;
        end else begin
          m_valid[m] = 1'b0;
        end
      end
    end
  endfunction

  // Advance one clock, keeping the model in step; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    vld  = 4'b0000;
    ordy = 1'b0;
    din  = 32'hA3A2A1A0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || od[m] !== 8'h00 || os[m] !== 2'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got v=%b d=%h s=%0d want v=0 d=00 s=0",
                 m, ov[m], od[m], os[m]);
      end
    end
    vld = 4'b1111;
    #1;
    total++;
    if (rdy[0] !== 4'b0000 || rdy[1] !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready: got %b/%b want 0000/0000", rdy[0], rdy[1]);
    end
    vld = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_rr_full();
    vld  = 4'b1111;
    ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (ov[0] !== 1'b1 || os[0] !== 2'(i % 4) || od[0] !== 8'hA0 + 8'(i % 4)) begin
        bad++;
        $display("FAIL rr_full cyc%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 i, ov[0], os[0], od[0], i % 4, 8'hA0 + 8'(i % 4));
      end
      total++;
      if (ov[1] !== 1'b1 || os[1] !== 2'd0 || od[1] !== 8'hA0) begin
        bad++;
        $display("FAIL fp_full cyc%0d: got v=%b s=%0d d=%h want v=1 s=0 d=a0",
                 i, ov[1], os[1], od[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (rdy[0] !== 4'b0000 || od[0] !== 8'hA1 || os[0] !== 2'd1 || ov[0] !== 1'b1) begin
        bad++;
        $display("FAIL backpressure cyc%0d: got rdy=%b d=%h s=%0d v=%b want 0000 a1 1 1",
                 i, rdy[0], od[0], os[0], ov[0]);
      end
      tick();
    end
    ordy = 1'b1;
    #1;
    total++;
    if (rdy[0] !== 4'b0100) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 0100", rdy[0]);
    end
    tick();
    total++;
    if (os[0] !== 2'd2 || od[0] !== 8'hA2) begin
      bad++;
      $display("FAIL bp_release_beat: got s=%0d d=%h want s=2 d=a2", os[0], od[0]);
    end
  endtask

  task automatic test_wrap();
    vld = 4'b0100;
    #1;
    total++;
    if (rdy[0] !== 4'b0100) begin
      bad++;
      $display("FAIL wrap_single_ready: got %b want 0100", rdy[0]);
    end
    tick();
    total++;
    if (os[0] !== 2'd2 || od[0] !== 8'hA2) begin
      bad++;
      $display("FAIL wrap_single_beat: got s=%0d d=%h want s=2 d=a2", os[0], od[0]);
    end
    vld = 4'b1001;
    #1;
    total++;
    if (rdy[0] !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_1001_ready: got %b want 1000", rdy[0]);
    end
    tick();
    total++;
    if (os[0] !== 2'd3 || od[0] !== 8'hA3) begin
      bad++;
      $display("FAIL wrap_1001_beat: got s=%0d d=%h want s=3 d=a3", os[0], od[0]);
    end
    // Pointer must have wrapped to 0.
    vld = 4'b1111;
    #1;
    total++;
    if (rdy[0] !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_ptr_zero: got %b want 0001", rdy[0]);
    end
    tick();
  endtask

  task automatic test_fixed();
    vld  = 4'b1111;
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (os[1] !== 2'd0 || ov[1] !== 1'b1) begin
        bad++;
        $display("FAIL fixed_all cyc%0d: got s=%0d v=%b want s=0 v=1", i, os[1], ov[1]);
      end
    end
    vld = 4'b1110;
    tick();
    total++;
    if (os[1] !== 2'd1 || od[1] !== 8'hA1) begin
      bad++;
      $display("FAIL fixed_drop0: got s=%0d d=%h want s=1 d=a1", os[1], od[1]);
    end
    vld = 4'b0000;
    tick();
    total++;
    if (ov[1] !== 1'b0 || od[1] !== 8'hA1) begin
      bad++;
      $display("FAIL fixed_drain: got v=%b d=%h want v=0 d=a1", ov[1], od[1]);
    end
  endtask

  task automatic test_drain_idle();
    vld  = 4'b1000;
    ordy = 1'b1;
    tick();
    vld = 4'b0000;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b1 || os[m] !== 2'd3 || od[m] !== 8'hA3) begin
        bad++;
        $display("FAIL drain_load dut%0d: got v=%b s=%0d d=%h want v=1 s=3 d=a3",
                 m, ov[m], os[m], od[m]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        total++;
        if (ov[m] !== 1'b0 || od[m] !== 8'hA3 || os[m] !== 2'd3) begin
          bad++;
          $display("FAIL drain_idle dut%0d cyc%0d: got v=%b d=%h s=%0d want v=0 d=a3 s=3",
                   m, i, ov[m], od[m], os[m]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vld  = 4'b1111;
    ordy = 1'b1;
    tick();
    tick();
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || od[m] !== 8'h00 || os[m] !== 2'd0 || rdy[m] !== 4'b0000) begin
        bad++;
        $display("FAIL reset_mid dut%0d: got v=%b d=%h s=%0d rdy=%b want 0 00 0 0000",
                 m, ov[m], od[m], os[m], rdy[m]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (rdy[0] !== 4'b0001 || rdy[1] !== 4'b0001) begin
      bad++;
      $display("FAIL reset_release_ready: got %b/%b want 0001/0001", rdy[0], rdy[1]);
    end
    tick();
    total++;
    if (os[0] !== 2'd0 || od[0] !== 8'hA0 || ov[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: got s=%0d d=%h v=%b want s=0 d=a0 v=1",
               os[0], od[0], ov[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      vld  = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      din  = $urandom;
      #1;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdy[m] !== exp_ready(m)) begin
          bad++;
          $display("FAIL rand_in_ready dut%0d cyc%0d: got %b want %b",
                   m, i, rdy[m], exp_ready(m));
        end
        total++;
        if (ov[m] !== m_valid[m] || od[m] !== m_data[m] || os[m] !== m_sel[m]) begin
          bad++;
          $display("FAIL rand_out dut%0d cyc%0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                   m, i, ov[m], od[m], os[m], m_valid[m], m_data[m], m_sel[m]);
        end
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rr_full();
    test_backpressure();
    test_wrap();
    test_fixed();
    test_drain_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel arbitrated multiplexer with one registered output stage and valid/ready handshakes on every input and on the output. It merges several producer streams (e.g. writeback or memory-request sources) into one consumer stream. Selection is round-robin or fixed-priority. Throughput is one beat per cycle with no bubbles under continuous demand.

## Interface
- LENGTH, 32, data width per channel in bits.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_WIDTH, 2, width of `out_sel`; must satisfy 2^SEL_WIDTH >= CHANNELS.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*LENGTH  packed channel data; channel i occupies bits [i*LENGTH +: LENGTH].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept; at most one bit set; combinational.
- out_data  output  LENGTH  registered selected data.
- out_sel  output  SEL_WIDTH  registered index of the channel that produced `out_data`.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

## Operation
- State consists of the output register (`out_data`, `out_sel`, `out_valid`) and the round-robin pointer `ptr` (SEL_WIDTH bits, range 0..CHANNELS-1).
- `can_load = !out_valid || out_ready`.
- Grant logic is combinational and produces a one-hot `grant`:
  - MODE 0: scan indices ptr, ptr+1, …, wrapping mod CHANNELS; the first index with `in_valid` set wins.
  - MODE 1: the lowest index with `in_valid` set wins; `ptr` is unused and stays 0.
- `in_ready = grant & {CHANNELS{can_load}}`. Force `in_ready` to all zeros while `rst` is high.
- Accept means `in_valid[g] && in_ready[g]` for the granted index g. On the next edge:
  - `out_data` ← channel g data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - MODE 0 only: `ptr` ← (g+1) mod CHANNELS. When g = CHANNELS-1, `ptr` wraps to 0.
- Drain without accept (`out_valid && out_ready`, no `in_valid` bit set): `out_valid` ← 0. `out_data` and `out_sel` hold. `ptr` holds.
- Drain and accept in the same cycle: the new beat loads directly, so there is no idle cycle.
- Stall (`out_valid && !out_ready`): all state holds and `in_ready` is all zeros.
- A channel whose `in_valid` is high but is not granted is not consumed. Producers must hold data stable until their `in_ready` is seen; the block does not check this.
- If `in_valid` is all zeros, there is no grant and `ptr` is unchanged.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
- Reset acts immediately on assertion, including mid-transfer. Any beat held in the output register is discarded.
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Sustained throughput is 1 beat per cycle while `out_ready`=1 and any `in_valid` is set.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`. It never depends on `in_data`.
- There is no combinational path from `in_data` to `out_data`.

## Test plan
Each scenario uses LENGTH=8, CHANNELS=4, SEL_WIDTH=2, with channel i driving data 8'hA0+i.

- **Reset mid-transfer.** Drive all channels valid; assert `rst` asynchronously between edges while `out_valid`=1 → `out_valid`, `out_data` and `out_sel` go to 0 immediately, and `in_ready`=0. After release, the first grant is channel 0.
- **Round-robin, full load (MODE 0).** All `in_valid`=1 and `out_ready`=1 for 6 cycles → `out_sel` sequence 0,1,2,3,0,1 and `out_data` sequence A0,A1,A2,A3,A0,A1 on consecutive cycles, with no bubbles.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while `out_valid`=1 with `out_sel`=1 → `out_data` stays A1, `in_ready` stays 4'b0000, `ptr` stays 2. Then raise `out_ready` → the next beat is channel 2 on the following cycle.
- **Wrap search.** With `ptr`=3, only `in_valid[2]`=1 → channel 2 is granted and `ptr` becomes 3. Then drive `in_valid`=4'b1001 → channel 3 is granted and `ptr` becomes 0.
- **Fixed priority (MODE 1).** All valid for 3 cycles → `out_sel` is 0 three times. Then drop `in_valid[0]` → `out_sel` becomes 1. Then drive `in_valid`=0 → `out_valid` falls after the last drain.
- **Drain then idle.** Accept one beat from channel 3, then drive `in_valid`=0 with `out_ready`=1 → `out_valid` is 1 for exactly one cycle. `out_data` holds A3 after `out_valid` drops.
